// File: rtl/fetch_stage_pkg.sv
// Shared CPU package: fetch FSM encoding, bubble word, opcode fields
// and the F/D bundle used by fetch_stage and its fd_latch.
package fetch_stage_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Major opcodes shared with next-PC and decode
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        valid;
    } fd_t;

    function automatic fd_t fd_make(
        input logic [31:0] pc,
        input logic [31:0] ir,
        input logic        valid
    );
        fd_t r;
        r.pc    = pc;
        r.ir    = ir;
        r.valid = valid;
        return r;
    endfunction

endpackage

// File: rtl/fetch_stage_fd_latch.sv
// F/D pipeline latch: 65-bit register with clear (bubble) over enable.
// Clear keeps the PC but replaces the instruction with the bubble word.
module fd_latch
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_WORD
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    input  fd_t  i_d,
    output fd_t  o_q
);

    fd_t r_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= fd_make(32'h0, NOP, 1'b0);
        end else if (i_clr) begin
            r_q <= fd_make(i_d.pc, NOP, 1'b0);
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, start latch, imem address and F/D latch.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          IMEM_AW = 12,
    parameter logic [31:0] NOP     = NOP_WORD
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [31:0]        pc_next,
    input  logic               stall,
    input  logic               flushJ,
    input  logic               flushB,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [31:0]        pc,
    output logic               on,
    output logic [31:0]        fd_pc,
    output logic [31:0]        fd_ir,
    output logic               fd_valid,
    output logic               dx_squash
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_stalls
`endif
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic         r_dx_squash;
    logic         w_run;
    logic         w_flush;
    logic         w_fd_en;
    logic         w_fd_clr;
    fd_t          w_fd_d;
    fd_t          w_fd_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   w_state_next = S_RUN;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_run    = (r_state == S_RUN);
    assign w_flush  = flushJ | flushB;
    assign w_fd_clr = w_run & w_flush;
    assign w_fd_en  = w_run & ~stall;
    assign w_fd_d   = fd_make(r_pc, imem_q, 1'b1);

    // ROM registers this address, so its data lines up with r_pc
    assign imem_addr = w_run ? pc_next[IMEM_AW-1:0] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc        <= 32'h0;
            r_dx_squash <= 1'b0;
        end else if (w_run) begin
            r_pc        <= pc_next;
            r_dx_squash <= flushB;
        end else begin
            r_pc        <= 32'h0;
            r_dx_squash <= 1'b0;
        end
    end

    fd_latch #(
        .NOP (NOP)
    ) u_fd (
        .clock (clock),
        .reset (reset),
        .i_en  (w_fd_en),
        .i_clr (w_fd_clr),
        .i_d   (w_fd_d),
        .o_q   (w_fd_q)
    );

    assign pc        = r_pc;
    assign on        = w_run;
    assign fd_pc     = w_fd_q.pc;
    assign fd_ir     = w_fd_q.ir;
    assign fd_valid  = w_fd_q.valid;
    assign dx_squash = r_dx_squash;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= 32'h0;
            r_perf_bubbles <= 32'h0;
            r_perf_stalls  <= 32'h0;
        end else if (w_run) begin
            if (w_flush) begin
                r_perf_bubbles <= r_perf_bubbles + 32'd1;
            end else if (stall) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end else begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_bubbles = r_perf_bubbles;
    assign perf_stalls  = r_perf_stalls;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed steps then random traffic against a
// cycle-level reference model with a behavioural registered ROM.
module tb_fetch_stage;

    localparam int          AW   = 12;
    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   pc_next;
    logic          stall;
    logic          flushJ;
    logic          flushB;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_q;
    logic [31:0]   pc;
    logic          on;
    logic [31:0]   fd_pc;
    logic [31:0]   fd_ir;
    logic          fd_valid;
    logic          dx_squash;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_bubbles;
    logic [31:0]   perf_stalls;
`endif

    fetch_stage #(
        .IMEM_AW (AW),
        .NOP     (NOPW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pc_next   (pc_next),
        .stall     (stall),
        .flushJ    (flushJ),
        .flushB    (flushB),
        .imem_addr (imem_addr),
        .imem_q    (imem_q),
        .pc        (pc),
        .on        (on),
        .fd_pc     (fd_pc),
        .fd_ir     (fd_ir),
        .fd_valid  (fd_valid),
        .dx_squash (dx_squash)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles),
        .perf_stalls  (perf_stalls)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] rom [0:(1<<AW)-1];

    always @(posedge clock) imem_q <= rom[imem_addr];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_run;
    logic [31:0] m_pc;
    logic [31:0] m_fd_pc;
    logic [31:0] m_fd_ir;
    logic        m_fd_v;
    logic        m_dx;
    logic [31:0] m_fet;
    logic [31:0] m_bub;
    logic [31:0] m_stl;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m_pc    = 32'h0;
        m_fd_pc = 32'h0;
        m_fd_ir = NOPW;
        m_fd_v  = 1'b0;
        m_dx    = 1'b0;
        m_fet   = 32'h0;
        m_bub   = 32'h0;
        m_stl   = 32'h0;
    endtask

    task automatic check_all(input string t);
        logic [31:0] ea;
        ea = m_run ? {20'h0, pc_next[AW-1:0]} : 32'h0;
        chk({t, ".pc"}, pc, m_pc);
        chk({t, ".on"}, {31'h0, on}, {31'h0, m_run});
        chk({t, ".fd_pc"}, fd_pc, m_fd_pc);
        chk({t, ".fd_ir"}, fd_ir, m_fd_ir);
        chk({t, ".fd_valid"}, {31'h0, fd_valid}, {31'h0, m_fd_v});
        chk({t, ".dx_squash"}, {31'h0, dx_squash}, {31'h0, m_dx});
        chk({t, ".imem_addr"}, {20'h0, imem_addr}, ea);
`ifdef FETCH_PERF_EN
        chk({t, ".perf_fetched"}, perf_fetched, m_fet);
        chk({t, ".perf_bubbles"}, perf_bubbles, m_bub);
        chk({t, ".perf_stalls"}, perf_stalls, m_stl);
`endif
    endtask

    task automatic drive(input logic s, input logic [31:0] pn,
                         input logic st, input logic fj, input logic fb);
        start   = s;
        pc_next = pn;
        stall   = st;
        flushJ  = fj;
        flushB  = fb;
    endtask

    // One clock edge: advance the model from pre-edge inputs, then compare
    task automatic tick(input string t);
        @(posedge clock);
        #1;
        if (m_run) begin
            if (flushJ | flushB) begin
                m_fd_pc = m_pc;
                m_fd_ir = NOPW;
                m_fd_v  = 1'b0;
                m_bub   = m_bub + 1;
            end else if (stall) begin
                m_stl = m_stl + 1;
            end else begin
                m_fd_pc = m_pc;
                m_fd_ir = rom[m_pc[AW-1:0]];
                m_fd_v  = 1'b1;
                m_fet   = m_fet + 1;
            end
            m_dx = flushB;
            m_pc = pc_next;
        end else if (start) begin
            m_run = 1'b1;
        end
        check_all(t);
    endtask

    initial begin
        logic [31:0] pn;
        int          r;
        logic        st, fj, fb;

        for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
        rom[0] = 32'h11;
        rom[1] = 32'h22;
        rom[2] = 32'h33;

        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #1;
        check_all("reset");
        #2;
        reset = 1'b0;

        tick("idle");

        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        tick("start");
        chk("start.on_first_edge", {31'h0, on}, 32'h1);

        drive(1'b0, m_pc + 1, 1'b0, 1'b0, 1'b0);
        tick("run1");
        chk("run1.fd_ir", fd_ir, 32'h11);
        drive(1'b0, m_pc + 1, 1'b0, 1'b0, 1'b0);
        tick("run2");
        chk("run2.fd_ir", fd_ir, 32'h22);
        chk("run2.pc", pc, 32'h2);

        while (m_pc != 32'd5) begin
            drive(1'b0, m_pc + 1, 1'b0, 1'b0, 1'b0);
            tick("to5");
        end

        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd5, 1'b1, 1'b0, 1'b0);
            tick("stall");
            chk("stall.pc_hold", pc, 32'd5);
            chk("stall.fd_pc_hold", fd_pc, 32'd4);
        end

        while (m_pc != 32'd7) begin
            drive(1'b0, m_pc + 1, 1'b0, 1'b0, 1'b0);
            tick("to7");
        end

        drive(1'b0, 32'h40, 1'b0, 1'b1, 1'b0);
        tick("flushJ");
        chk("flushJ.fd_ir", fd_ir, NOPW);
        chk("flushJ.pc", pc, 32'h40);
        drive(1'b0, 32'h41, 1'b0, 1'b0, 1'b0);
        tick("flushJ_next");
        chk("flushJ_next.fd_ir", fd_ir, rom[12'h40]);

        drive(1'b0, 32'h80, 1'b1, 1'b0, 1'b1);
        tick("flushB_stall");
        chk("flushB_stall.dx", {31'h0, dx_squash}, 32'h1);
        chk("flushB_stall.pc", pc, 32'h80);
        drive(1'b0, 32'h81, 1'b0, 1'b0, 1'b0);
        tick("flushB_after");
        chk("flushB_after.dx", {31'h0, dx_squash}, 32'h0);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 9);
            fj = (r == 0);
            fb = (r == 1);
            st = (r == 2) || (r == 3) || ((r == 1) && ($urandom_range(0, 1) == 1));
            if (fj | fb)  pn = $urandom;
            else if (st)  pn = m_pc;
            else          pn = m_pc + 1;
            drive(($urandom_range(0, 3) == 0), pn, st, fj, fb);
            tick("rand");
        end

        drive(1'b0, 32'h123, 1'b0, 1'b0, 1'b0);
        tick("to123");
        chk("to123.pc", pc, 32'h123);
        drive(1'b0, 32'h124, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        #2;
        reset = 1'b0;

        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
            tick("idle_hold");
            chk("idle_hold.imem_addr", {20'h0, imem_addr}, 32'h0);
        end

        drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        tick("restart");
        drive(1'b0, 32'h1, 1'b0, 1'b0, 1'b0);
        tick("restart1");
        chk("restart1.fd_ir", fd_ir, 32'h11);

        drive(1'b0, 32'h0000_1003, 1'b0, 1'b0, 1'b0);
        #1;
        chk("wrap.imem_addr", {20'h0, imem_addr}, 32'h3);
        tick("wrap");
        chk("wrap.pc", pc, 32'h0000_1003);
        drive(1'b0, 32'h0000_1004, 1'b0, 1'b0, 1'b0);
        tick("wrap_next");
        chk("wrap_next.fd_ir", fd_ir, rom[3]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
